// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a synchronous FIFO one word per frame.
// Frame: start bit, LSB-first data, optional parity, STOP_BITS stop bits.
//
// state  | meaning
// IDLE   | line high, pops the FIFO head when tx_en=1 and FIFO not empty
// START  | start bit (tx=0)
// DATA   | data bits, LSB first
// PARITY | parity bit (only when PARITY_EN=1)
// STOP   | stop bit(s), tx=1
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done_tick
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W  = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [CNT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  baud_tc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

  assign baud_tc = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d      = state_q;
    baud_d       = baud_tc ? '0 : baud_q + 1'b1;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    parity_d     = parity_q;
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!reset && tx_en && !fifo_empty) begin
          fifo_rd  = 1'b1;
          shreg_d  = fifo_r_data;
          parity_d = (^fifo_r_data) ^ (PARITY_ODD != 0);
          state_d  = START;
        end
      end
      START: begin
        if (baud_tc) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (baud_tc) begin
          shreg_d = shreg_q >> 1;
          if (bit_q == CNT_W'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_tc) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
      STOP: begin
        if (baud_tc) begin
          if (bit_q == CNT_W'(STOP_BITS - 1)) begin
            tx_done_tick = 1'b1;
            state_d      = IDLE;
            bit_d        = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Line value is registered from the next state so tx never glitches.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: three configurations driven from emulated FIFOs,
// every cycle compared against a frame-waveform reference model.
module tb_uart_tx_fifo_drain;

  localparam int CPB = 4;
  localparam int PE[3] = '{0, 1, 1};
  localparam int PO[3] = '{0, 0, 1};
  localparam int SB[3] = '{1, 2, 1};

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_en;
  logic       emp [3];
  logic [7:0] rdat [3];
  logic       rd_o [3];
  logic       tx_o [3];
  logic       busy_o [3];
  logic       done_o [3];

  // Emulated FIFOs (env head follows DUT pops) and model heads (follow the model).
  logic [7:0] fbuf [3][256];
  logic [7:0] ftail [3];
  logic [7:0] fhead [3];
  logic [7:0] mhead [3];
  int         rem [3];
  int         flen [3];
  logic       wave [3][64];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      emp[k]  = (fhead[k] == ftail[k]);
      rdat[k] = fbuf[k][fhead[k]];
    end
  end

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(SB[0]),
                       .PARITY_EN(PE[0]), .PARITY_ODD(PO[0])) dut0 (
    .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_empty(emp[0]),
    .fifo_r_data(rdat[0]), .fifo_rd(rd_o[0]), .tx(tx_o[0]), .busy(busy_o[0]),
    .tx_done_tick(done_o[0]));

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(SB[1]),
                       .PARITY_EN(PE[1]), .PARITY_ODD(PO[1])) dut1 (
    .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_empty(emp[1]),
    .fifo_r_data(rdat[1]), .fifo_rd(rd_o[1]), .tx(tx_o[1]), .busy(busy_o[1]),
    .tx_done_tick(done_o[1]));

  uart_tx_fifo_drain #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(SB[2]),
                       .PARITY_EN(PE[2]), .PARITY_ODD(PO[2])) dut2 (
    .clk(clk), .reset(reset), .tx_en(tx_en), .fifo_empty(emp[2]),
    .fifo_r_data(rdat[2]), .fifo_rd(rd_o[2]), .tx(tx_o[2]), .busy(busy_o[2]),
    .tx_done_tick(done_o[2]));

  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cfg%0d t=%0t observed=%b expected=%b", tag, k, $time, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    for (int k = 0; k < 3; k++) begin
      fbuf[k][ftail[k]] = w;
      ftail[k] = ftail[k] + 8'd1;
    end
  endtask

  // Expected line waveform of one frame, one entry per clock.
  task automatic build(input int k, input logic [7:0] w);
    logic bits [12];
    int   n;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < 8; i++) begin bits[n] = w[i]; n++; end
    if (PE[k] != 0) begin bits[n] = (^w) ^ (PO[k] != 0); n++; end
    for (int s = 0; s < SB[k]; s++) begin bits[n] = 1'b1; n++; end
    for (int i = 0; i < n * CPB; i++) wave[k][i] = bits[i / CPB];
    flen[k] = n * CPB;
    rem[k]  = n * CPB;
  endtask

  task automatic cycle();
    logic erd [3];
    logic pop [3];
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      erd[k] = !reset && rem[k] == 0 && tx_en && (mhead[k] != ftail[k]);
      chk("fifo_rd", k, rd_o[k], erd[k]);
      chk("tx", k, tx_o[k], (rem[k] == 0) ? 1'b1 : wave[k][flen[k] - rem[k]]);
      chk("busy", k, busy_o[k], rem[k] != 0);
      chk("tx_done_tick", k, done_o[k], rem[k] == 1);
      pop[k] = rd_o[k];
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (pop[k] === 1'b1) fhead[k] = fhead[k] + 8'd1;
      if (erd[k]) begin
        build(k, fbuf[k][mhead[k]]);
        mhead[k] = mhead[k] + 8'd1;
      end else if (rem[k] > 0) begin
        rem[k]--;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset = 1'b1;
    tx_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ftail[k] = '0; fhead[k] = '0; mhead[k] = '0; rem[k] = 0; flen[k] = 0;
      for (int i = 0; i < 64; i++) wave[k][i] = 1'b1;
    end
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("reset_tx", k, tx_o[k], 1'b1);
      chk("reset_busy", k, busy_o[k], 1'b0);
      chk("reset_rd", k, rd_o[k], 1'b0);
      chk("reset_done", k, done_o[k], 1'b0);
    end
    run(2);
    reset = 1'b0;

    // Word waits while tx_en=0, then a single frame.
    push(8'hA5);
    run(10);
    tx_en = 1'b1;
    run(55);

    // Back-to-back drain.
    push(8'h00); push(8'hFF); push(8'h3C);
    run(160);

    // Parity: 0x07 has three ones.
    push(8'h07);
    run(55);

    // Drop tx_en mid-frame: frame completes, second word stays queued.
    push(8'h5A); push(8'hC3);
    run(20);
    tx_en = 1'b0;
    run(60);

    // Reset during DATA: line high at once, in-flight word dropped.
    tx_en = 1'b1;
    run(15);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) rem[k] = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("midreset_tx", k, tx_o[k], 1'b1);
      chk("midreset_busy", k, busy_o[k], 1'b0);
    end
    run(3);
    reset = 1'b0;
    run(110);

    // Randomized pushes and tx_en toggling.
    for (int r = 0; r < 14; r++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int j = 0; j < nw; j++) push(8'($urandom));
      tx_en = ($urandom_range(0, 3) != 0);
      run($urandom_range(5, 70));
    end
    tx_en = 1'b1;
    run(50 * 45);

    for (int k = 0; k < 3; k++) chk("drained", k, emp[k], 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
